// File: rtl/dmem_subword.sv
// dmem_subword: byte/halfword/word data memory for the MIPS32 load/store stage.
// Latency: loads return one cycle after the request edge; stores land at the request edge.
// Backpressure: ready=0 during the post-reset clear sweep; requests are then ignored entirely.
//
// Ports:
//   clock, reset              single rising-edge clock, synchronous active-high reset
//   address, size, sign_ext   byte address, access size (00 B, 01 H, 1x W), load extension
//   mem_write, data_write     store request, right-justified store data
//   mem_read                  load request
//   read_data, read_valid     registered load result and its one-cycle valid pulse
//   ready                     high once the array has been zeroed
//   out_of_range, misaligned  sticky error flags, cleared only by reset
//
// Optional feature: define DMEM_ALIGN_CHECK_EN to reject misaligned halfword/word
// accesses and report them on `misaligned`; otherwise low address bits are forced
// to natural alignment and `misaligned` is tied low.

module dmem_subword #(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] address,
    input  logic        mem_write,
    input  logic        mem_read,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [31:0] data_write,
    output logic [31:0] read_data,
    output logic        read_valid,
    output logic        ready,
    output logic        out_of_range,
    output logic        misaligned
);

    localparam int              AW      = $clog2(DEPTH_WORDS);
    localparam logic [31:0]     DEPTH32 = 32'(DEPTH_WORDS);
    localparam logic [AW-1:0]   LAST    = AW'(DEPTH_WORDS - 1);

    typedef enum logic {S_CLEAR, S_RUN} state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   clr_cnt_q, clr_cnt_d;
    logic [31:0]     mem_q [DEPTH_WORDS];
    logic [31:0]     rdata_q, rdata_d;
    logic            rvld_q, rvld_d;
    logic            oor_q, oor_d;

    // Address decode
    logic [29:0]     word_off;
    logic            in_range;
    logic [AW-1:0]   word_idx;
    logic [1:0]      lane;
    logic            mis_acc;
    logic            access_ok;

    // Write port (shared by the clear sweep and stores)
    logic            mem_we;
    logic [AW-1:0]   waddr;
    logic [31:0]     wdat;
    logic [3:0]      wbe;

    // Load path
    logic [31:0]     rd_word;
    logic [31:0]     shifted;
    logic [31:0]     load_val;

    logic [3:0]      st_be;
    logic [31:0]     st_dat;

    always_comb begin
        word_off = 30'((address - BASE_ADDR) >> 2);
        // The subtraction wraps for addresses below the base, so check both bounds.
        in_range = (address >= BASE_ADDR) && ({2'b00, word_off} < DEPTH32);
        word_idx = word_off[AW-1:0];

        // Lane is forced to natural alignment; with checking enabled a
        // misaligned access never reaches the array anyway.
        if (size[1])            lane = 2'b00;
        else if (size[0])       lane = {address[1], 1'b0};
        else                    lane = address[1:0];

`ifdef DMEM_ALIGN_CHECK_EN
        mis_acc = (size == 2'b01 && address[0]) || (size[1] && (address[1:0] != 2'b00));
`else
        mis_acc = 1'b0;
`endif
        access_ok = in_range && !mis_acc;
    end

    // Store byte enables and lane-replicated data
    always_comb begin
        case (size)
            2'b00: begin
                st_be  = 4'b0001 << address[1:0];
                st_dat = {4{data_write[7:0]}};
            end
            2'b01: begin
                st_be  = address[1] ? 4'b1100 : 4'b0011;
                st_dat = {2{data_write[15:0]}};
            end
            default: begin
                st_be  = 4'b1111;
                st_dat = data_write;
            end
        endcase
    end

    // Load extraction and extension
    always_comb begin
        rd_word = mem_q[word_idx];
        shifted = rd_word >> {lane, 3'b000};
        case (size)
            2'b00:   load_val = {{24{sign_ext & shifted[7]}},  shifted[7:0]};
            2'b01:   load_val = {{16{sign_ext & shifted[15]}}, shifted[15:0]};
            default: load_val = shifted;
        endcase
    end

    // FSM next-state and datapath control
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        mem_we    = 1'b0;
        waddr     = word_idx;
        wdat      = st_dat;
        wbe       = st_be;
        rvld_d    = 1'b0;
        rdata_d   = rdata_q;
        oor_d     = oor_q;

        case (state_q)
            S_CLEAR: begin
                mem_we    = 1'b1;
                waddr     = clr_cnt_q;
                wdat      = 32'h0;
                wbe       = 4'b1111;
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (clr_cnt_q == LAST) begin
                    state_d = S_RUN;
                end
            end
            default: begin
                // The load reads the array before this edge's store lands,
                // which gives read-before-write on a same-word collision.
                if (mem_write && access_ok) begin
                    mem_we = 1'b1;
                end
                if (mem_read) begin
                    rvld_d  = 1'b1;
                    rdata_d = access_ok ? load_val : 32'h0;
                end
                if ((mem_read || mem_write) && !in_range) begin
                    oor_d = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_CLEAR;
            clr_cnt_q <= '0;
            rdata_q   <= 32'h0;
            rvld_q    <= 1'b0;
            oor_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            rdata_q   <= rdata_d;
            rvld_q    <= rvld_d;
            oor_q     <= oor_d;
        end
    end

    always_ff @(posedge clock) begin
        if (mem_we && !reset) begin
            for (int b = 0; b < 4; b++) begin
                if (wbe[b]) begin
                    mem_q[waddr][8*b +: 8] <= wdat[8*b +: 8];
                end
            end
        end
    end

`ifdef DMEM_ALIGN_CHECK_EN
    logic mis_q, mis_d;

    always_comb begin
        mis_d = mis_q;
        if (state_q == S_RUN && (mem_read || mem_write) && mis_acc) begin
            mis_d = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            mis_q <= 1'b0;
        end else begin
            mis_q <= mis_d;
        end
    end

    assign misaligned = mis_q;
`else
    assign misaligned = 1'b0;
`endif

    assign read_data    = rdata_q;
    assign read_valid   = rvld_q;
    assign ready        = (state_q == S_RUN);
    assign out_of_range = oor_q;

endmodule

// File: tb/tb_dmem_subword.sv
// Testbench for dmem_subword: randomized traffic against a byte-array reference model,
// with directed literal checks for the documented scenarios.
module tb_dmem_subword;

    localparam int          DEPTH = 64;
    localparam logic [31:0] BASE  = 32'h0000_0000;

    logic        clock;
    logic        reset;
    logic [31:0] address;
    logic        mem_write;
    logic        mem_read;
    logic [1:0]  size;
    logic        sign_ext;
    logic [31:0] data_write;
    logic [31:0] read_data;
    logic        read_valid;
    logic        ready;
    logic        out_of_range;
    logic        misaligned;

    dmem_subword #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE)) dut (
        .clock        (clock),
        .reset        (reset),
        .address      (address),
        .mem_write    (mem_write),
        .mem_read     (mem_read),
        .size         (size),
        .sign_ext     (sign_ext),
        .data_write   (data_write),
        .read_data    (read_data),
        .read_valid   (read_valid),
        .ready        (ready),
        .out_of_range (out_of_range),
        .misaligned   (misaligned)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Reference model: plain byte array plus expected output state.
    logic [7:0]  mdl [DEPTH*4];
    logic        exp_vld, exp_oor, exp_mis;
    logic [31:0] exp_dat;
    logic        nx_vld, nx_oor, nx_mis;
    logic [31:0] nx_dat;
    bit          chk_en = 1'b0;

    task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (chk_en) begin
            lit("read_valid",   {31'b0, read_valid},   {31'b0, exp_vld});
            lit("read_data",    read_data,             exp_dat);
            lit("ready",        {31'b0, ready},        32'd1);
            lit("out_of_range", {31'b0, out_of_range}, {31'b0, exp_oor});
            lit("misaligned",   {31'b0, misaligned},   {31'b0, exp_mis});
        end
    end

    task automatic model_step(input bit rd, input bit wr, input logic [1:0] sz,
                              input bit sx, input logic [31:0] a, input logic [31:0] d);
        int          n;
        logic [31:0] ea;
        bit          inr, mis;
        logic [31:0] v;
        n   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        inr = (a >= BASE) && (((a - BASE) / 4) < DEPTH);
        ea  = a - (a % n);
`ifdef DMEM_ALIGN_CHECK_EN
        mis = (a % n) != 0;
`else
        mis = 1'b0;
`endif
        nx_vld = rd;
        nx_dat = exp_dat;
        if (rd) begin
            v = 32'h0;
            if (inr && !mis) begin
                for (int i = 0; i < n; i++) v = v | (32'(mdl[ea - BASE + i]) << (8*i));
                if (sx && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
            end
            nx_dat = v;
        end
        if (wr && inr && !mis) begin
            for (int i = 0; i < n; i++) mdl[ea - BASE + i] = d[8*i +: 8];
        end
        nx_oor = exp_oor | ((rd | wr) & !inr);
        nx_mis = exp_mis | ((rd | wr) & mis);
    endtask

    task automatic cyc(input bit rd, input bit wr, input logic [1:0] sz,
                       input bit sx, input logic [31:0] a, input logic [31:0] d);
        mem_read   = rd;
        mem_write  = wr;
        size       = sz;
        sign_ext   = sx;
        address    = a;
        data_write = d;
        model_step(rd, wr, sz, sx, a, d);
        @(posedge clock);
        #1;
        exp_vld = nx_vld;
        exp_dat = nx_dat;
        exp_oor = nx_oor;
        exp_mis = nx_mis;
    endtask

    task automatic do_reset();
        chk_en    = 1'b0;
        reset     = 1'b1;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        repeat (2) begin
            @(posedge clock);
            #1;
        end
        lit("rst_read_data",    read_data,             32'h0);
        lit("rst_read_valid",   {31'b0, read_valid},   32'h0);
        lit("rst_ready",        {31'b0, ready},        32'h0);
        lit("rst_out_of_range", {31'b0, out_of_range}, 32'h0);
        lit("rst_misaligned",   {31'b0, misaligned},   32'h0);
        for (int i = 0; i < DEPTH*4; i++) mdl[i] = 8'h00;
        exp_vld = 1'b0;
        exp_dat = 32'h0;
        exp_oor = 1'b0;
        exp_mis = 1'b0;
    endtask

    // Release reset and count edges until ready; optionally fire requests that must be ignored.
    task automatic sweep(input bit noisy, output int n, output bit bad);
        reset = 1'b0;
        n     = 0;
        bad   = 1'b0;
        while (!ready && n <= 4*DEPTH) begin
            if (noisy) begin
                mem_read   = 1'($urandom);
                mem_write  = 1'($urandom);
                size       = 2'($urandom);
                sign_ext   = 1'($urandom);
                address    = $urandom_range(0, DEPTH*8);
                data_write = $urandom;
            end
            @(posedge clock);
            #1;
            n++;
            if (read_valid || out_of_range || misaligned) bad = 1'b1;
        end
        mem_read  = 1'b0;
        mem_write = 1'b0;
    endtask

    task automatic rand_cycles(input int count);
        logic [31:0] a;
        for (int k = 0; k < count; k++) begin
            if ($urandom_range(0, 15) == 0) a = BASE + $urandom_range(4*DEPTH, 4*DEPTH + 64);
            else                            a = BASE + $urandom_range(0, 4*DEPTH - 1);
            cyc(1'($urandom), 1'($urandom), 2'($urandom), 1'($urandom), a, $urandom);
        end
    endtask

    int n;
    bit bad;

    initial begin
        reset = 1'b1; mem_read = 1'b0; mem_write = 1'b0; size = 2'b10;
        sign_ext = 1'b0; address = 32'h0; data_write = 32'h0;

        // Sweep length and mid-sweep restart
        do_reset();
        sweep(1'b0, n, bad);
        lit("sweep_len", 32'(n), 32'(DEPTH));
        do_reset();
        reset = 1'b0;
        repeat (10) begin
            @(posedge clock);
            #1;
        end
        lit("ready_mid_sweep", {31'b0, ready}, 32'h0);
        do_reset();
        sweep(1'b1, n, bad);
        lit("restart_sweep_len", 32'(n), 32'(DEPTH));
        lit("ignored_while_clearing", {31'b0, bad}, 32'h0);
        chk_en = 1'b1;

        // Directed scenarios
        cyc(1, 0, 2'b10, 0, BASE + 32'h0, 0);
        lit("load0_model", exp_dat, 32'h0);
        lit("load0",       read_data, 32'h0);

        cyc(0, 1, 2'b10, 0, BASE + 32'h8, 32'h1234_ABCD);
        cyc(0, 1, 2'b00, 0, BASE + 32'h9, 32'h0000_00EE);
        cyc(0, 1, 2'b00, 0, BASE + 32'hB, 32'h0000_0077);
        cyc(1, 0, 2'b10, 0, BASE + 32'h8, 0);
        lit("merge_model", exp_dat, 32'h7734_EECD);
        lit("merge_word",  read_data, 32'h7734_EECD);
        cyc(1, 0, 2'b00, 1, BASE + 32'h9, 0);
        lit("lb_sx_model", exp_dat, 32'hFFFF_FFEE);
        lit("lb_sx",       read_data, 32'hFFFF_FFEE);
        cyc(1, 0, 2'b00, 0, BASE + 32'h9, 0);
        lit("lbu",         read_data, 32'h0000_00EE);
        cyc(1, 0, 2'b01, 1, BASE + 32'hA, 0);
        lit("lh_sx_model", exp_dat, 32'h0000_7734);
        lit("lh_sx",       read_data, 32'h0000_7734);

        cyc(0, 1, 2'b10, 0, BASE + 32'h10, 32'h500);
        cyc(1, 1, 2'b10, 0, BASE + 32'h10, 32'h400);
        lit("rbw_old",     read_data, 32'h500);
        cyc(1, 0, 2'b10, 0, BASE + 32'h10, 0);
        lit("rbw_new",     read_data, 32'h400);
        cyc(0, 0, 2'b10, 0, 0, 0);
        lit("hold_data",   read_data, 32'h400);
        lit("valid_drop",  {31'b0, read_valid}, 32'h0);

        cyc(0, 1, 2'b10, 0, BASE + 32'(4*DEPTH), 32'hCAFE_F00D);
        lit("oor_flag",    {31'b0, out_of_range}, 32'h1);
        cyc(1, 0, 2'b10, 0, BASE + 32'(4*DEPTH), 0);
        lit("oor_load",    read_data, 32'h0);
        lit("oor_valid",   {31'b0, read_valid}, 32'h1);
        cyc(1, 0, 2'b10, 0, BASE + 32'h0, 0);
        lit("oor_no_wrap", read_data, 32'h0);

        cyc(0, 1, 2'b10, 0, BASE + 32'h6, 32'hDEAD_BEEF);
        cyc(1, 0, 2'b10, 0, BASE + 32'h4, 0);
`ifdef DMEM_ALIGN_CHECK_EN
        lit("mis_word",    read_data, 32'h0);
        lit("mis_flag",    {31'b0, misaligned}, 32'h1);
`else
        lit("mis_word",    read_data, 32'hDEAD_BEEF);
        lit("mis_flag",    {31'b0, misaligned}, 32'h0);
`endif

        // Randomized traffic
        rand_cycles(1500);

        // Reset after dirty traffic: the sweep must zero every word
        do_reset();
        sweep(1'b1, n, bad);
        lit("dirty_sweep_len", 32'(n), 32'(DEPTH));
        lit("dirty_ignored",   {31'b0, bad}, 32'h0);
        chk_en = 1'b1;
        for (int w = 0; w < DEPTH; w++) cyc(1, 0, 2'b10, 0, BASE + 32'(4*w), 0);
        rand_cycles(400);

        chk_en = 1'b0;
        @(negedge clock);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
